// File: rtl/muldiv_defs.sv
// ---------------------------------------------------------------------------
// muldiv_defs
// Shared definitions for the iterative multiply/divide unit: operation
// encodings as issued by the decoder, the FSM state encoding, and small
// helpers that classify an operation.
// ---------------------------------------------------------------------------
package muldiv_defs;

   // Operation encoding on the op port.
   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_e;

   // FSM states of the iterative engine.
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_FIX  = 2'b10,
      ST_DONE = 2'b11
   } state_e;

   // Bit 0 clear selects the signed flavour (mult/div).
   function automatic logic op_is_signed(input logic [1:0] op);
      return ~op[0];
   endfunction

   // Bit 1 set selects a divide (div/divu).
   function automatic logic op_is_div(input logic [1:0] op);
      return op[1];
   endfunction

endpackage

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
// One operation per start pulse; the result reaches HI/LO WIDTH+2 cycles
// after the start edge. Signed operations run on magnitudes and are sign
// corrected in a dedicated FIX cycle.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   start        begin an operation (only honoured in IDLE)
//   op           00 mult, 01 multu, 10 div, 11 divu
//   a, b         rs / rt operands
//   mthi, mtlo   write wdata to HI / LO (idle, no start)
//   wdata        data for mthi/mtlo
//   busy         operation in progress (state != IDLE)
//   done         one-cycle pulse when HI/LO take a result
//   div_by_zero  one-cycle pulse with done for a divide by zero
//   hi, lo       HI and LO registers
// ---------------------------------------------------------------------------
module muldiv_unit
   import muldiv_defs::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             mthi,
   input  logic             mtlo,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   // Two's-complement negation under control of a flag.
   function automatic logic [WIDTH-1:0] cond_neg_w(input logic [WIDTH-1:0] v,
                                                   input logic             n);
      return n ? (~v + 1'b1) : v;
   endfunction

   function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic [2*WIDTH-1:0] v,
                                                      input logic               n);
      return n ? (~v + 1'b1) : v;
   endfunction

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q;

   logic                 is_div_q;
   logic                 neg_a_q;
   logic                 neg_b_q;
   logic                 b_zero_q;
   logic [WIDTH-1:0]     raw_a_q;
   // Multiplicand (mult) or divisor (div) magnitude.
   logic [WIDTH-1:0]     opnd_q;
   // Mult: {partial product, remaining multiplier bits}.
   // Div:  {partial remainder, dividend bits / quotient bits}.
   logic [2*WIDTH-1:0]   acc_q;
   logic [WIDTH-1:0]     res_hi_q;
   logic [WIDTH-1:0]     res_lo_q;
   logic                 dbz_q;

   logic                 start_ok;
   logic                 in_signed;
   logic                 in_neg_a;
   logic                 in_neg_b;
   logic signed [WIDTH-1:0] in_a_s;
   logic signed [WIDTH-1:0] in_b_s;
   logic [WIDTH-1:0]     in_mag_a;
   logic [WIDTH-1:0]     in_mag_b;

   logic [WIDTH:0]       mul_sum;
   logic [2*WIDTH-1:0]   mul_next;
   logic [WIDTH:0]       div_shift;
   logic [WIDTH+1:0]     div_diff;
   logic [2*WIDTH-1:0]   div_next;

   logic [WIDTH-1:0]     fix_hi;
   logic [WIDTH-1:0]     fix_lo;
   logic                 fix_dbz;
   logic [2*WIDTH-1:0]   prod_fix;

   assign busy     = (state_q != ST_IDLE);
   assign start_ok = (state_q == ST_IDLE) && start;

   // Operand capture: signed ops keep only magnitudes plus sign bits.
   assign in_signed = op_is_signed(op);
   assign in_a_s    = a;
   assign in_b_s    = b;
   assign in_neg_a  = in_signed && (in_a_s < 0);
   assign in_neg_b  = in_signed && (in_b_s < 0);
   assign in_mag_a  = cond_neg_w(a, in_neg_a);
   assign in_mag_b  = cond_neg_w(b, in_neg_b);

   // Shift-add multiply step: add the multiplicand when the current
   // multiplier LSB is set, then shift the whole accumulator right.
   always_comb begin
      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
      mul_next = {mul_sum, acc_q[WIDTH-1:1]};
   end

   // Restoring divide step: shift the next dividend bit into the remainder,
   // trial-subtract the divisor and keep the difference if it did not borrow.
   // On a failed subtract the shifted remainder is below the divisor, so its
   // top bit is zero and dropping it is lossless.
   always_comb begin
      div_shift = acc_q[2*WIDTH-1:WIDTH-1];
      div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};
      if (div_diff[WIDTH+1]) begin
         div_next = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end else begin
         div_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end
   end

   // Sign correction. The signed-overflow divide falls out naturally: the
   // magnitude quotient 2^(WIDTH-1) is left un-negated, i.e. most-negative.
   always_comb begin
      fix_hi   = '0;
      fix_lo   = '0;
      fix_dbz  = 1'b0;
      prod_fix = cond_neg_2w(acc_q, neg_a_q ^ neg_b_q);
      if (is_div_q) begin
         if (b_zero_q) begin
            fix_hi  = raw_a_q;
            fix_lo  = '1;
            fix_dbz = 1'b1;
         end else begin
            fix_lo = cond_neg_w(acc_q[WIDTH-1:0], neg_a_q ^ neg_b_q);
            fix_hi = cond_neg_w(acc_q[2*WIDTH-1:WIDTH], neg_a_q);
         end
      end else begin
         fix_hi = prod_fix[2*WIDTH-1:WIDTH];
         fix_lo = prod_fix[WIDTH-1:0];
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start) state_d = ST_RUN;
         ST_RUN:  if (cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_FIX;
         ST_FIX:  state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Control and architectural state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         hi          <= '0;
         lo          <= '0;
      end else begin
         state_q     <= state_d;
         done        <= (state_q == ST_DONE);
         div_by_zero <= (state_q == ST_DONE) && dbz_q;
         if (start_ok) begin
            cnt_q <= '0;
         end else if (state_q == ST_RUN) begin
            cnt_q <= cnt_q + 1'b1;
         end
         if (state_q == ST_DONE) begin
            hi <= res_hi_q;
            lo <= res_lo_q;
         end else if (state_q == ST_IDLE && !start) begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
         end
      end
   end

   // Datapath registers; their contents are meaningless until a start
   // loads them, so they carry no reset.
   always_ff @(posedge clk) begin
      if (start_ok) begin
         is_div_q <= op_is_div(op);
         neg_a_q  <= in_neg_a;
         neg_b_q  <= in_neg_b;
         b_zero_q <= (b == '0);
         raw_a_q  <= a;
         opnd_q   <= op_is_div(op) ? in_mag_b : in_mag_a;
         acc_q    <= {{WIDTH{1'b0}}, (op_is_div(op) ? in_mag_a : in_mag_b)};
      end else if (state_q == ST_RUN) begin
         acc_q <= is_div_q ? div_next : mul_next;
      end else if (state_q == ST_FIX) begin
         res_hi_q <= fix_hi;
         res_lo_q <= fix_lo;
         dbz_q    <= fix_dbz;
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit
// Self-checking bench for muldiv_unit at WIDTH=32: fixed vector table,
// handshake corner sequences, randomized operations against an arithmetic
// reference model, and a reset-abort sequence.
// ---------------------------------------------------------------------------
module tb_muldiv_unit;

   localparam int W = 32;
   localparam int LAT = W + 2;

   logic          clk;
   logic          reset;
   logic          start;
   logic [1:0]    op;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          mthi;
   logic          mtlo;
   logic [W-1:0]  wdata;
   logic          busy;
   logic          done;
   logic          div_by_zero;
   logic [W-1:0]  hi;
   logic [W-1:0]  lo;

   int n_pass;
   int n_total;

   muldiv_unit #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .busy(busy), .done(done),
      .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [1:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dbz;
      string        name;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // Reference model: plain arithmetic on the architectural definitions.
   function automatic void model(input logic [1:0] o, input logic [W-1:0] x,
                                 input logic [W-1:0] y, output logic [W-1:0] rhi,
                                 output logic [W-1:0] rlo, output logic rdbz);
      longint          sp;
      longint unsigned up;
      int              sx, sy;
      rdbz = 1'b0;
      sx = x;
      sy = y;
      case (o)
         2'b00: begin
            sp  = longint'(sx) * longint'(sy);
            rhi = sp[63:32];
            rlo = sp[31:0];
         end
         2'b01: begin
            up  = {32'd0, x} * {32'd0, y};
            rhi = up[63:32];
            rlo = up[31:0];
         end
         default: begin
            if (y == 0) begin
               rhi  = x;
               rlo  = '1;
               rdbz = 1'b1;
            end else if (o == 2'b11) begin
               rlo = x / y;
               rhi = x % y;
            end else if (x == 32'h8000_0000 && sy == -1) begin
               rlo = 32'h8000_0000;
               rhi = '0;
            end else begin
               rlo = sx / sy;
               rhi = sx % sy;
            end
         end
      endcase
   endfunction

   // Issue one operation (called at a falling edge) and follow it to done.
   // inj_kind: 0 none, 1 extra start at cycle inj_k, 2 mthi at cycle inj_k,
   // 3 mtlo asserted together with the start.
   task automatic run_op(input logic [1:0] o, input logic [W-1:0] ia,
                         input logic [W-1:0] ib, input logic [W-1:0] ehi,
                         input logic [W-1:0] elo, input logic edbz,
                         input string nm, input int inj_k, input int inj_kind);
      logic [W-1:0] hi_b, lo_b;
      int  lat;
      bit  busy_ok, hold_ok;
      hi_b = hi;
      lo_b = lo;
      start = 1'b1;
      op = o;
      a = ia;
      b = ib;
      if (inj_kind == 3) begin
         mtlo  = 1'b1;
         wdata = 32'hDEAD_BEEF;
      end
      lat = -1;
      busy_ok = 1'b1;
      hold_ok = 1'b1;
      for (int k = 0; k < LAT + 6; k++) begin
         @(negedge clk);
         start = 1'b0;
         mthi  = 1'b0;
         mtlo  = 1'b0;
         if (done) begin
            lat = k;
            break;
         end
         if (!busy) busy_ok = 1'b0;
         if (hi !== hi_b || lo !== lo_b) hold_ok = 1'b0;
         if (k == inj_k && inj_kind == 1) begin
            start = 1'b1;
            op = 2'b10;
            a = 32'd99;
            b = 32'd3;
         end
         if (k == inj_k && inj_kind == 2) begin
            mthi  = 1'b1;
            wdata = 32'h1234;
         end
      end
      chk({nm, "_latency"}, lat, LAT);
      chk({nm, "_busy_during"}, busy_ok, 1);
      chk({nm, "_hilo_hold"}, hold_ok, 1);
      chk({nm, "_busy_at_done"}, busy, 0);
      chk({nm, "_hi"}, hi, ehi);
      chk({nm, "_lo"}, lo, elo);
      chk({nm, "_dbz"}, div_by_zero, edbz);
      @(negedge clk);
      chk({nm, "_done_pulse"}, {done, div_by_zero}, 2'b00);
   endtask

   initial begin
      logic [W-1:0] rh, rl, ra, rb;
      logic         rd;
      logic [1:0]   ro;
      int           sel;
      bit           no_done;

      n_pass = 0;
      n_total = 0;
      reset = 1'b1;
      start = 1'b0;
      op = 2'b00;
      a = '0;
      b = '0;
      mthi = 1'b0;
      mtlo = 1'b0;
      wdata = '0;

      vecs[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, "multu_max"};
      vecs[1] = '{2'b00, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, "mult_m3x7"};
      vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "div_m7d2"};
      vecs[3] = '{2'b11, 32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF, 1'b1, "divu_by0"};
      vecs[4] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, "div_ovf"};
      vecs[5] = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, "div_7dm2"};
      vecs[6] = '{2'b11, 32'hFFFF_FFFF, 32'd16,        32'h0000_000F, 32'h0FFF_FFFF, 1'b0, "divu_max16"};
      vecs[7] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, "mult_minmin"};
      vecs[8] = '{2'b10, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, "div_neg_by0"};

      repeat (2) @(negedge clk);
      chk("reset_state", {busy, done, div_by_zero, hi, lo}, '0);
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 9; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo,
                vecs[i].dbz, vecs[i].name, -1, 0);
      end

      // Second start while busy must be ignored.
      run_op(2'b01, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0, "start_collide", 3, 1);
      // mthi while busy must be ignored.
      run_op(2'b01, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0, "mthi_busy", 5, 2);

      mthi = 1'b1;
      wdata = 32'h1234;
      @(negedge clk);
      mthi = 1'b0;
      chk("mthi_idle", {hi, lo}, {32'h1234, 32'd30});

      mthi = 1'b1;
      mtlo = 1'b1;
      wdata = 32'hABCD;
      @(negedge clk);
      mthi = 1'b0;
      mtlo = 1'b0;
      chk("mthi_mtlo_both", {hi, lo}, {32'hABCD, 32'hABCD});

      // Start and mtlo together: start wins, LO must not take wdata.
      run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0,
             "start_wins_mtlo", -1, 3);

      for (int i = 0; i < 40; i++) begin
         ro = 2'($urandom_range(0, 3));
         ra = $urandom;
         rb = $urandom;
         sel = $urandom_range(0, 7);
         if (sel == 0) rb = '0;
         else if (sel == 1) begin
            ra = 32'h8000_0000;
            rb = 32'hFFFF_FFFF;
         end else if (sel == 2) rb = 32'($urandom_range(1, 15));
         model(ro, ra, rb, rh, rl, rd);
         run_op(ro, ra, rb, rh, rl, rd, "rand", -1, 0);
      end

      // Reset mid-operation aborts and clears HI/LO.
      mthi = 1'b1;
      mtlo = 1'b1;
      wdata = 32'h5A5A_5A5A;
      @(negedge clk);
      mthi = 1'b0;
      mtlo = 1'b0;
      start = 1'b1;
      op = 2'b11;
      a = 32'd1000;
      b = 32'd7;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         start = 1'b0;
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("reset_abort", {busy, done, hi, lo}, '0);
      no_done = 1'b1;
      for (int k = 0; k < LAT + 4; k++) begin
         @(negedge clk);
         if (done || busy) no_done = 1'b0;
      end
      chk("reset_abort_no_done", no_done, 1);
      model(2'b00, 32'd1000, 32'hFFFF_FFFE, rh, rl, rd);
      run_op(2'b00, 32'd1000, 32'hFFFF_FFFE, rh, rl, rd, "after_reset", -1, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
